spi_slave_ram_if: RTL and testbench

Parametrised SPI slave front-end that deserialises MOSI command/payload frames for the single-port RAM and serialises RAM read data back on MISO. Successor to the fixed 10-bit SPI slave: payload width is a parameter, read data is shifted out bit-serially under a handshake, and aborted frames are detected and reported. It sits between the SPI pins and the RAM's din/rx_valid/dout/tx_valid ports, sampling SPI signals on the system clock.

---
 rtl/spi_slave_ram_if.sv | 109 ++++++++++
 tb/tb_spi_slave_ram_if.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_ram_if.sv
// spi_slave_ram_if: SPI slave front-end that deserialises command/payload frames for a RAM and serialises read data back
//   clk       system clock; SPI pins are sampled on its rising edge
//   rst       synchronous active-high reset
//   MOSI      serial data in, MSB first
//   SS_n      active-low slave select; a high level ends the current frame
//   tx_data   read data from the RAM
//   tx_valid  tx_data valid; accepted only while waiting to transmit
//   MISO      serial data out, MSB first; 0 when not shifting
//   rx_valid  one-cycle pulse; rx_data holds a complete {cmd, payload} frame
//   rx_data   last complete frame {cmd[1:0], payload}
//   frame_err one-cycle pulse; SS_n rose before a frame or read completed
module spi_slave_ram_if #(
    parameter int PAYLOAD_W = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   MOSI,
    input  logic                   SS_n,
    input  logic [PAYLOAD_W-1:0]   tx_data,
    input  logic                   tx_valid,
    output logic                   MISO,
    output logic                   rx_valid,
    output logic [PAYLOAD_W+1:0]   rx_data,
    output logic                   frame_err
);
    localparam int W  = PAYLOAD_W + 2;
    localparam int CW = $clog2(W);
    localparam logic [CW-1:0] LAST = CW'(PAYLOAD_W + 1);
    localparam logic [CW-1:0] TXN  = CW'(PAYLOAD_W);

    typedef enum logic [2:0] {
        IDLE, CHK_CMD, WRITE, READ_ADDR, READ_DATA, TX_WAIT, TX_SHIFT, DONE
    } state_t;

    state_t               state;
    logic [CW-1:0]        cnt;
    logic [W-2:0]         rx_sr;
    logic [PAYLOAD_W-1:0] tx_sr;
    logic                 rd_addr_done;
    logic [W-1:0]         rx_next;

    assign rx_next = {rx_sr, MOSI};

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            rx_sr        <= '0;
            tx_sr        <= '0;
            rd_addr_done <= 1'b0;
            MISO         <= 1'b0;
            rx_valid     <= 1'b0;
            rx_data      <= '0;
            frame_err    <= 1'b0;
        end else begin
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            if (SS_n && state != IDLE) begin
                // Deselect wins over any bit on this edge; only DONE is a clean end
                state     <= IDLE;
                cnt       <= '0;
                rx_sr     <= '0;
                tx_sr     <= '0;
                MISO      <= 1'b0;
                frame_err <= (state != DONE);
            end else begin
                case (state)
                    IDLE: if (!SS_n) state <= CHK_CMD;
                    CHK_CMD: begin
                        rx_sr <= rx_next[W-2:0];
                        cnt   <= CW'(1);
                        state <= !MOSI ? WRITE : (rd_addr_done ? READ_DATA : READ_ADDR);
                    end
                    WRITE, READ_ADDR, READ_DATA: begin
                        rx_sr <= rx_next[W-2:0];
                        cnt   <= cnt + CW'(1);
                        if (cnt == LAST) begin
                            rx_data  <= rx_next;
                            rx_valid <= 1'b1;
                            cnt      <= '0;
                            if (state == READ_ADDR) rd_addr_done <= 1'b1;
                            state <= (state == READ_DATA) ? TX_WAIT : DONE;
                        end
                    end
                    TX_WAIT: if (tx_valid) begin
                        // MSB goes out immediately; tx_sr holds the remaining bits left-aligned
                        tx_sr <= tx_data << 1;
                        MISO  <= tx_data[PAYLOAD_W-1];
                        cnt   <= CW'(1);
                        state <= TX_SHIFT;
                    end
                    TX_SHIFT: begin
                        if (cnt == TXN) begin
                            MISO         <= 1'b0;
                            rd_addr_done <= 1'b0;
                            cnt          <= '0;
                            state        <= DONE;
                        end else begin
                            MISO  <= tx_sr[PAYLOAD_W-1];
                            tx_sr <= tx_sr << 1;
                            cnt   <= cnt + CW'(1);
                        end
                    end
                    DONE: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_spi_slave_ram_if.sv
// tb_spi_slave_ram_if: directed self-checking bench for spi_slave_ram_if with PAYLOAD_W=8
module tb_spi_slave_ram_if;
    logic       clk = 1'b0;
    logic       rst, MOSI, SS_n, tx_valid;
    logic [7:0] tx_data;
    logic       MISO, rx_valid, frame_err;
    logic [9:0] rx_data;

    int checks = 0;
    int passes = 0;
    int nv, nf, nm, nboth;

    spi_slave_ram_if #(.PAYLOAD_W(8)) dut (
        .clk(clk), .rst(rst), .MOSI(MOSI), .SS_n(SS_n),
        .tx_data(tx_data), .tx_valid(tx_valid),
        .MISO(MISO), .rx_valid(rx_valid), .rx_data(rx_data), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        if (rx_valid === 1'b1) nv++;
        if (frame_err === 1'b1) nf++;
        if (MISO === 1'b1) nm++;
        if (rx_valid === 1'b1 && frame_err === 1'b1) nboth++;
    endtask

    task automatic clr();
        nv = 0; nf = 0; nm = 0;
    endtask

    task automatic frame(input logic [9:0] f);
        SS_n = 1'b0;
        MOSI = 1'b0;
        tick();
        for (int i = 9; i >= 0; i--) begin
            MOSI = f[i];
            tick();
        end
    endtask

    task automatic end_frame();
        SS_n = 1'b1;
        MOSI = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1; SS_n = 1'b1; MOSI = 1'b0; tx_valid = 1'b0; tx_data = 8'h00;
        tick(); tick();
        checks++; if (MISO !== 1'b0) $display("FAIL reset_miso: got %b want 0", MISO); else passes++;
        checks++; if (rx_valid !== 1'b0) $display("FAIL reset_rx_valid: got %b want 0", rx_valid); else passes++;
        checks++; if (rx_data !== 10'h000) $display("FAIL reset_rx_data: got %h want 000", rx_data); else passes++;
        checks++; if (frame_err !== 1'b0) $display("FAIL reset_frame_err: got %b want 0", frame_err); else passes++;
        rst = 1'b0;
        tick();
        nboth = 0;
    endtask

    task automatic test_write();
        clr();
        frame(10'b00_10100101);
        checks++; if (rx_valid !== 1'b1) $display("FAIL wr_rx_valid: got %b want 1", rx_valid); else passes++;
        checks++; if (rx_data !== 10'h0A5) $display("FAIL wr_rx_data: got %h want 0a5", rx_data); else passes++;
        tick();
        checks++; if (rx_valid !== 1'b0) $display("FAIL wr_rx_valid_width: got %b want 0", rx_valid); else passes++;
        end_frame();
        checks++; if (frame_err !== 1'b0) $display("FAIL wr_done_exit_err: got %b want 0", frame_err); else passes++;
        tick();
        checks++; if (nv !== 1) $display("FAIL wr_valid_count: got %0d want 1", nv); else passes++;
        checks++; if (nm !== 0) $display("FAIL wr_miso_quiet: got %0d high cycles want 0", nm); else passes++;
        checks++; if (nf !== 0) $display("FAIL wr_no_err: got %0d want 0", nf); else passes++;
    endtask

    task automatic test_read();
        logic [7:0] exp;
        exp = 8'hC3;
        clr();
        frame(10'b10_00110011);
        checks++; if (rx_data !== 10'h233 || rx_valid !== 1'b1) $display("FAIL rd_addr_frame: got %h/%b want 233/1", rx_data, rx_valid); else passes++;
        end_frame();
        checks++; if (frame_err !== 1'b0) $display("FAIL rd_addr_exit_err: got %b want 0", frame_err); else passes++;
        frame(10'b11_01010101);
        checks++; if (rx_data !== 10'h355 || rx_valid !== 1'b1) $display("FAIL rd_data_frame: got %h/%b want 355/1", rx_data, rx_valid); else passes++;
        tick(); tick();
        checks++; if (MISO !== 1'b0) $display("FAIL tx_wait_miso: got %b want 0", MISO); else passes++;
        tx_data = exp; tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0; tx_data = 8'h00;
        for (int k = 0; k < 8; k++) begin
            checks++; if (MISO !== exp[7-k]) $display("FAIL tx_bit%0d: got %b want %b", k, MISO, exp[7-k]); else passes++;
            tick();
        end
        checks++; if (MISO !== 1'b0) $display("FAIL tx_end_miso: got %b want 0", MISO); else passes++;
        end_frame();
        checks++; if (frame_err !== 1'b0) $display("FAIL tx_done_exit_err: got %b want 0", frame_err); else passes++;
        tick();
        checks++; if (nf !== 0) $display("FAIL rd_no_err: got %0d want 0", nf); else passes++;
    endtask

    task automatic test_rd_cleared();
        clr();
        frame(10'b11_00001111);
        checks++; if (rx_data !== 10'h30F || rx_valid !== 1'b1) $display("FAIL rdc_frame: got %h/%b want 30f/1", rx_data, rx_valid); else passes++;
        tx_data = 8'hFF; tx_valid = 1'b1;
        tick(); tick();
        tx_valid = 1'b0;
        checks++; if (MISO !== 1'b0) $display("FAIL rdc_no_tx: got %b want 0", MISO); else passes++;
        end_frame();
        checks++; if (frame_err !== 1'b0) $display("FAIL rdc_exit_err: got %b want 0", frame_err); else passes++;
        tick();
    endtask

    task automatic test_abort();
        logic [9:0] f;
        f = 10'b00_10110110;
        clr();
        SS_n = 1'b0; tick();
        for (int i = 9; i >= 5; i--) begin
            MOSI = f[i];
            tick();
        end
        end_frame();
        checks++; if (frame_err !== 1'b1) $display("FAIL abort_err: got %b want 1", frame_err); else passes++;
        tick();
        checks++; if (frame_err !== 1'b0) $display("FAIL abort_err_width: got %b want 0", frame_err); else passes++;
        checks++; if (nv !== 0 || nf !== 1) $display("FAIL abort_counts: got valid=%0d err=%0d want 0/1", nv, nf); else passes++;
        clr();
        SS_n = 1'b0; tick();
        for (int i = 9; i >= 1; i--) begin
            MOSI = f[i];
            tick();
        end
        SS_n = 1'b1; MOSI = f[0];
        tick();
        checks++; if (frame_err !== 1'b1 || rx_valid !== 1'b0) $display("FAIL abort_last_bit: got err=%b valid=%b want 1/0", frame_err, rx_valid); else passes++;
        tick();
        frame(10'b01_11110000);
        checks++; if (rx_data !== 10'h1F0 || rx_valid !== 1'b1) $display("FAIL abort_recover: got %h/%b want 1f0/1", rx_data, rx_valid); else passes++;
        end_frame();
        tick();
        checks++; if (nv !== 1 || nf !== 1) $display("FAIL abort_last_counts: got valid=%0d err=%0d want 1/1", nv, nf); else passes++;
    endtask

    task automatic test_rst_tx();
        rst = 1'b1; tick(); rst = 1'b0; tick();
        frame(10'b10_00000001);
        end_frame();
        frame(10'b11_00000000);
        tx_data = 8'hA5; tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
        checks++; if (MISO !== 1'b1) $display("FAIL rst_tx_bit0: got %b want 1", MISO); else passes++;
        tick();
        checks++; if (MISO !== 1'b0) $display("FAIL rst_tx_bit1: got %b want 0", MISO); else passes++;
        tick();
        checks++; if (MISO !== 1'b1) $display("FAIL rst_tx_bit2: got %b want 1", MISO); else passes++;
        rst = 1'b1; SS_n = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (MISO !== 1'b0 || frame_err !== 1'b0) $display("FAIL rst_tx_miso: got miso=%b err=%b want 0/0", MISO, frame_err); else passes++;
        tick();
        frame(10'b11_11001100);
        checks++; if (rx_data !== 10'h3CC || rx_valid !== 1'b1) $display("FAIL rst_tx_next: got %h/%b want 3cc/1", rx_data, rx_valid); else passes++;
        tx_data = 8'hFF; tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
        checks++; if (MISO !== 1'b0) $display("FAIL rst_tx_rdaddr: got %b want 0", MISO); else passes++;
        end_frame();
        checks++; if (frame_err !== 1'b0) $display("FAIL rst_tx_exit_err: got %b want 0", frame_err); else passes++;
        tick();
    endtask

    task automatic test_tx_ignored();
        clr();
        tx_data = 8'hFF; tx_valid = 1'b1;
        tick(); tick(); tick();
        frame(10'b00_01100110);
        checks++; if (rx_data !== 10'h066 || rx_valid !== 1'b1) $display("FAIL ign_frame: got %h/%b want 066/1", rx_data, rx_valid); else passes++;
        tx_valid = 1'b0;
        end_frame();
        checks++; if (frame_err !== 1'b0) $display("FAIL ign_exit_err: got %b want 0", frame_err); else passes++;
        tick();
        checks++; if (nm !== 0) $display("FAIL ign_miso: got %0d high cycles want 0", nm); else passes++;
    endtask

    initial begin
        nboth = 0;
        test_reset();
        test_write();
        test_read();
        test_rd_cleared();
        test_abort();
        test_rst_tx();
        test_tx_ignored();
        checks++; if (nboth !== 0) $display("FAIL valid_err_exclusive: got %0d overlap cycles want 0", nboth); else passes++;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
